// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass and a per-register
// busy scoreboard that counts in-flight producers for RAW hazard detection.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              all_idle
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;

  logic wr_ok;
  logic resv_ok;
  logic zero_a;
  logic zero_b;
  logic byp_a;
  logic byp_b;

  assign zero_a  = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign zero_b  = (ZERO_REG != 0) && (rd_addr_b == '0);
  assign wr_ok   = wr_en && !rst &&
                   !((ZERO_REG != 0) && (wr_addr == '0));
  assign resv_ok = resv_en && !rst &&
                   !((ZERO_REG != 0) && (resv_addr == '0));
  assign byp_a   = wr_ok && (wr_addr == rd_addr_a);
  assign byp_b   = wr_ok && (wr_addr == rd_addr_b);

  // Reserve is applied after the write clear so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[wr_addr] = 1'b0;
    if (resv_ok)
      busy_nxt[resv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok)
        mem[wr_addr] <= wr_data;
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    rd_data_a = mem[rd_addr_a];
    rd_busy_a = busy[rd_addr_a];
    if (zero_a) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end else if (byp_a) begin
      rd_data_a = wr_data;
      rd_busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = mem[rd_addr_b];
    rd_busy_b = busy[rd_addr_b];
    if (zero_b) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end else if (byp_b) begin
      rd_data_b = wr_data;
      rd_busy_b = 1'b0;
    end
  end

  assign pending_cnt = cnt;
  assign all_idle    = (cnt == '0);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic
// compared each cycle against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        rd_busy_a;
  logic        rd_busy_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        resv_en;
  logic [2:0]  resv_addr;
  logic [3:0]  pending_cnt;
  logic        all_idle;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_reg  [8];
  bit          m_busy [8];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr),
    .pending_cnt(pending_cnt), .all_idle(all_idle)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++)
      n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [15:0] m_rdata(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (wr_en && !rst && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic m_rbusy(input logic [2:0] a);
    if (a == 3'd0) return 1'b0;
    if (wr_en && !rst && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic compare();
    int n;
    n = m_count();
    chk("rd_data_a", 32'(rd_data_a), 32'(m_rdata(rd_addr_a)));
    chk("rd_data_b", 32'(rd_data_b), 32'(m_rdata(rd_addr_b)));
    chk("rd_busy_a", 32'(rd_busy_a), 32'(m_rbusy(rd_addr_a)));
    chk("rd_busy_b", 32'(rd_busy_b), 32'(m_rbusy(rd_addr_b)));
    chk("pending_cnt", 32'(pending_cnt), 32'(n));
    chk("all_idle", 32'(all_idle), 32'(n == 0));
  endtask

  task automatic drive(input logic r,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic we, input logic [2:0] wa,
                       input logic [15:0] wd,
                       input logic re, input logic [2:0] rsa);
    @(negedge clk);
    rst = r; rd_addr_a = ra; rd_addr_b = rb;
    wr_en = we; wr_addr = wa; wr_data = wd;
    resv_en = re; resv_addr = rsa;
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = 16'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 3'd0) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (resv_en && resv_addr != 3'd0)
        m_busy[resv_addr] = 1'b1;
    end
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    drive(1'b0, ra, rb, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = 16'h0;
      m_busy[i] = 1'b0;
    end
    rst = 1'b1; rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0;
    @(posedge clk);
    @(posedge clk);

    for (int a = 0; a < 8; a++) begin
      idle(3'(a), 3'(7 - a));
      chk("reset data", 32'(rd_data_a), 32'h0);
      chk("reset busy", 32'(rd_busy_b), 32'h0);
      chk("reset idle", 32'(all_idle), 32'h1);
      tick();
    end

    drive(1'b0, 3'd3, 3'd0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
    chk("bypass beef", 32'(rd_data_a), 32'hBEEF);
    tick();
    idle(3'd3, 3'd0);
    chk("stored beef", 32'(rd_data_a), 32'hBEEF);
    tick();

    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 16'h1234, 1'b1, 3'd0);
    chk("zero data", 32'(rd_data_a), 32'h0);
    chk("zero busy", 32'(rd_busy_a), 32'h0);
    tick();
    idle(3'd0, 3'd0);
    chk("zero cnt", 32'(pending_cnt), 32'h0);
    tick();

    drive(1'b0, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
    tick();
    drive(1'b0, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
    chk("cnt one", 32'(pending_cnt), 32'h1);
    tick();
    drive(1'b0, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7);
    chk("cnt two", 32'(pending_cnt), 32'h2);
    tick();
    drive(1'b0, 3'd5, 3'd7, 1'b1, 3'd5, 16'h5A5A, 1'b0, 3'd0);
    chk("cnt three", 32'(pending_cnt), 32'h3);
    chk("not idle", 32'(all_idle), 32'h0);
    chk("busy bypass", 32'(rd_busy_a), 32'h0);
    chk("busy seven", 32'(rd_busy_b), 32'h1);
    tick();
    drive(1'b0, 3'd4, 3'd4, 1'b1, 3'd4, 16'h00AA, 1'b1, 3'd4);
    chk("cnt after wr5", 32'(pending_cnt), 32'h2);
    tick();
    idle(3'd4, 3'd1);
    chk("reg4 data", 32'(rd_data_a), 32'h00AA);
    chk("reg4 busy", 32'(rd_busy_a), 32'h1);
    chk("cnt reg4", 32'(pending_cnt), 32'h3);
    tick();

    drive(1'b1, 3'd1, 3'd4, 1'b1, 3'd1, 16'h5555, 1'b1, 3'd6);
    chk("rst no bypass", 32'(rd_data_a), 32'h0);
    tick();
    idle(3'd1, 3'd4);
    chk("rst reg1", 32'(rd_data_a), 32'h0);
    chk("rst reg4", 32'(rd_data_b), 32'h0);
    chk("rst cnt", 32'(pending_cnt), 32'h0);
    chk("rst idle", 32'(all_idle), 32'h1);
    tick();

    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 59) == 0),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            16'($urandom),
            ($urandom_range(0, 1) == 0), 3'($urandom_range(0, 7)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the single-cycle/pipelined MIPS datapath, replacing the fixed 8×16 file. It keeps two combinational read ports and one write port with an optional hardwired-zero register 0. It adds same-cycle write-to-read bypass, a synchronous reset that clears all storage, and a per-register busy scoreboard with a pending-count output so the control unit can detect RAW hazards against in-flight producers.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth = 2^ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and reservations; 0 = register 0 is ordinary
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_addr_a  input  ADDR_W  read port A address
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_a  output  DATA_W  port A data (combinational)
- rd_data_b  output  DATA_W  port B data (combinational)
- rd_busy_a  output  1  port A register has a pending producer
- rd_busy_b  output  1  port B register has a pending producer
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- resv_en  input  1  reserve (mark busy) request
- resv_addr  input  ADDR_W  register to reserve
- pending_cnt  output  ADDR_W+1  number of registers currently busy
- all_idle  output  1  pending_cnt == 0

## Operation
- Storage: 2^ADDR_W × DATA_W registers plus 2^ADDR_W busy bits plus pending_cnt register.
- Reset: rst high at a rising edge clears all registers to 0, all busy bits to 0, and pending_cnt to 0. wr_en and resv_en are ignored in any cycle where rst is high. Reset mid-operation discards all pending reservations.
- Write: wr_en at a rising edge stores wr_data into reg[wr_addr] and clears busy[wr_addr]. It is ignored for address 0 when ZERO_REG=1.
- Reserve: resv_en at a rising edge sets busy[resv_addr]. It is ignored for address 0 when ZERO_REG=1.
  - Reserving an already-busy register keeps it busy, with no count change.
- Simultaneous write and reserve, same address: data is written and busy ends at 1 (the new producer wins).
- Simultaneous write and reserve, different addresses: both take effect independently.
- Write to a non-busy register: data is stored and busy is unchanged.
- Read data, per port:
  - ZERO_REG=1 and addr==0: 0.
  - Else if wr_en && !rst && wr_addr==addr: wr_data (bypass).
  - Else: reg[addr].
- Read busy, per port:
  - ZERO_REG=1 and addr==0: 0.
  - Else if wr_en && !rst && wr_addr==addr: 0 (producer completes this cycle).
  - Else: busy[addr].
  - A reservation in the current cycle does not affect read outputs until after the edge.
- pending_cnt next value = popcount of the next busy vector. An incremental update (+1 on a 0→1 transition, −1 on a 1→0 transition) is acceptable if the results are identical.
- pending_cnt never exceeds 2^ADDR_W (2^ADDR_W−1 when ZERO_REG=1). all_idle is combinational from pending_cnt.

## Timing
- Read path: zero-latency combinational from addresses and the write inputs. No clock edge is needed to observe a write on the read port.
- Write and reserve: take effect at the rising edge and are visible in stored state from the next cycle.
- Busy clear via write is visible on rd_busy in the same cycle as wr_en (bypass); the stored busy bit clears at the edge.
- pending_cnt and all_idle update one edge after the write/reserve that changes them.
- After the reset edge: rd_data_a/b = 0 for all addresses, rd_busy_a/b = 0, pending_cnt = 0, all_idle = 1.
- While rst is held high, read outputs still bypass? No: the bypass is suppressed while rst is high, so outputs reflect stored (cleared) state.

## Test plan
- Reset then read all addresses: every rd_data = 0, rd_busy = 0, pending_cnt = 0, all_idle = 1.
- wr_en=1, wr_addr=3, wr_data=16'hBEEF, rd_addr_a=3 in the same cycle → rd_data_a = BEEF combinationally; after the edge, with wr_en=0, rd_data_a is still BEEF.
- ZERO_REG=1: write 16'h1234 to reg 0 and reserve reg 0 → rd_data_a = 0, rd_busy_a = 0, pending_cnt = 0.
- Reserve regs 2, 5, 7 on three successive edges → pending_cnt = 1, 2, 3, all_idle = 0. Write reg 5 → rd_busy 0 in the same cycle, pending_cnt = 2 after the edge.
- Same edge: resv_addr=4 and wr_addr=4 with data 16'h00AA, reg 4 previously idle → reg4 = 00AA, busy[4] = 1, pending_cnt +1.
- Reserve 3 registers, then assert rst for one edge together with wr_en to reg 1 → all data 0, pending_cnt = 0, reg 1 not written.
